// File: rtl/gyruss_spram_pkg.sv
// Shared types and constants for the double-buffered sprite attribute RAM.
package gyruss_spram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int SPR_BYTES  = 256;
    localparam int SPR_STRIDE = 4;

endpackage

// File: rtl/gyruss_dpram.sv
// Generic true dual-port RAM with registered reads; port A can be write-first,
// port B is always read-first.
module gyruss_dpram #(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter bit A_WRITE_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_dout
);

    logic [DW-1:0] mem_r [0:(2**AW)-1];

    // Array writes from both ports; contents are never cleared
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem_r[a_addr] <= a_din;
        end
        if (b_we) begin
            mem_r[b_addr] <= b_din;
        end
    end

    // Registered read data for both ports
    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout <= {DW{1'b0}};
            b_dout <= {DW{1'b0}};
        end else begin
            if (A_WRITE_FIRST && a_we) begin
                a_dout <= a_din;
            end else begin
                a_dout <= mem_r[a_addr];
            end
            b_dout <= mem_r[b_addr];
        end
    end

endmodule

// File: rtl/gyruss_spram_shadow.sv
// Double-buffered sprite attribute RAM: CPU work RAM copied into the back
// shadow bank on each vblank rise, banks swapped only if vblank is still high.
module gyruss_spram_shadow
    import gyruss_spram_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          VCLKx8,
    input  logic          RESET,
    input  logic          VBLK,
    input  logic [AW-1:0] CPUAD,
    input  logic [DW-1:0] CPUDI,
    input  logic          CPUWE,
    output logic [DW-1:0] CPUDO,
    input  logic [AW-1:0] SPAA,
    output logic [DW-1:0] SPAD,
    output logic          BUSY,
    output logic          SWAP,
    output logic          DROP,
    output logic          BANK
);

    state_t        state_r;
    logic [AW-1:0] cnt_r;
    logic          vblk_r;
    logic          busy_r;
    logic          swap_r;
    logic          drop_r;
    logic          bank_r;

    logic          rise_s;
    logic          sh_we_s;
    logic [AW:0]   sh_waddr_s;
    logic [DW-1:0] copy_rd_s;
    logic [DW-1:0] shadow_unused_s;

    // Write-back stage lags the read address by one cycle, so the write goes to cnt-1
    always_comb begin
        rise_s     = VBLK & ~vblk_r;
        sh_waddr_s = {~bank_r, cnt_r - AW'(1)};
        case (state_r)
            COPY:    sh_we_s = (cnt_r != {AW{1'b0}});
            FLUSH:   sh_we_s = 1'b1;
            default: sh_we_s = 1'b0;
        endcase
    end

    // Copy sequencer, vblank edge register and status pulses
    always_ff @(posedge VCLKx8) begin
        if (RESET) begin
            state_r <= IDLE;
            cnt_r   <= {AW{1'b0}};
            vblk_r  <= 1'b0;
            busy_r  <= 1'b0;
            swap_r  <= 1'b0;
            drop_r  <= 1'b0;
            bank_r  <= 1'b0;
        end else begin
            vblk_r <= VBLK;
            swap_r <= 1'b0;
            drop_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r <= COPY;
                        cnt_r   <= {AW{1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                COPY: begin
                    cnt_r <= cnt_r + AW'(1);
                    if (cnt_r == {AW{1'b1}}) begin
                        state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    // A frame whose vblank already ended is thrown away to avoid tearing
                    if (VBLK) begin
                        bank_r <= ~bank_r;
                        swap_r <= 1'b1;
                    end else begin
                        drop_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    gyruss_dpram #(
        .AW            (AW),
        .DW            (DW),
        .A_WRITE_FIRST (1'b1)
    ) u_work (
        .clk    (VCLKx8),
        .rst    (RESET),
        .a_we   (CPUWE),
        .a_addr (CPUAD),
        .a_din  (CPUDI),
        .a_dout (CPUDO),
        .b_we   (1'b0),
        .b_addr (cnt_r),
        .b_din  ({DW{1'b0}}),
        .b_dout (copy_rd_s)
    );

    gyruss_dpram #(
        .AW            (AW + 1),
        .DW            (DW),
        .A_WRITE_FIRST (1'b0)
    ) u_shadow (
        .clk    (VCLKx8),
        .rst    (RESET),
        .a_we   (sh_we_s),
        .a_addr (sh_waddr_s),
        .a_din  (copy_rd_s),
        .a_dout (shadow_unused_s),
        .b_we   (1'b0),
        .b_addr ({bank_r, SPAA}),
        .b_din  ({DW{1'b0}}),
        .b_dout (SPAD)
    );

    assign BUSY = busy_r;
    assign SWAP = swap_r;
    assign DROP = drop_r;
    assign BANK = bank_r;

endmodule

// File: tb/tb_gyruss_spram_shadow.sv
// Directed self-checking bench for gyruss_spram_shadow.
module tb_gyruss_spram_shadow;

    logic       VCLKx8;
    logic       RESET;
    logic       VBLK;
    logic [7:0] CPUAD;
    logic [7:0] CPUDI;
    logic       CPUWE;
    logic [7:0] CPUDO;
    logic [7:0] SPAA;
    logic [7:0] SPAD;
    logic       BUSY;
    logic       SWAP;
    logic       DROP;
    logic       BANK;

    int checks;
    int errors;

    gyruss_spram_shadow #(.AW(8), .DW(8)) dut (
        .VCLKx8 (VCLKx8),
        .RESET  (RESET),
        .VBLK   (VBLK),
        .CPUAD  (CPUAD),
        .CPUDI  (CPUDI),
        .CPUWE  (CPUWE),
        .CPUDO  (CPUDO),
        .SPAA   (SPAA),
        .SPAD   (SPAD),
        .BUSY   (BUSY),
        .SWAP   (SWAP),
        .DROP   (DROP),
        .BANK   (BANK)
    );

    initial VCLKx8 = 1'b0;
    always #5 VCLKx8 = ~VCLKx8;

    task automatic tick();
        @(posedge VCLKx8);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        CPUAD = a;
        CPUDI = d;
        CPUWE = 1'b1;
        tick();
        CPUWE = 1'b0;
    endtask

    task automatic spr_read(input logic [7:0] a, output logic [7:0] d);
        SPAA = a;
        tick();
        d = SPAD;
    endtask

    // One vblank frame of 300 cycles; iteration k observes the state after the k-th edge from the rise
    task automatic run_copy(input int fall_at, input int rise_at, input int rst_at, input int wr_at,
                            output int busy_n, output int swap_n, output int drop_n,
                            output int swap_at, output logic [7:0] spad_flush,
                            output logic [7:0] spad_after);
        busy_n = 0;
        swap_n = 0;
        drop_n = 0;
        swap_at = -1;
        spad_flush = 8'h00;
        spad_after = 8'h00;
        SPAA = 8'hFF;
        VBLK = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (BUSY) busy_n++;
            if (SWAP) begin swap_n++; swap_at = k; end
            if (DROP) drop_n++;
            if (k == 257) spad_flush = SPAD;
            if (k == 258) spad_after = SPAD;
            RESET = (k == rst_at);
            if (k == fall_at || k == rst_at) VBLK = 1'b0;
            if (k == rise_at) VBLK = 1'b1;
            CPUWE = 1'b0;
            if (k == wr_at) begin CPUAD = 8'h10; CPUDI = 8'h33; CPUWE = 1'b1; end
            if (k == wr_at + 1) begin CPUAD = 8'hF0; CPUDI = 8'h44; CPUWE = 1'b1; end
        end
        VBLK = 1'b0;
        RESET = 1'b0;
        CPUWE = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        VBLK = 1'b0;
        CPUWE = 1'b0;
        CPUAD = 8'h00;
        CPUDI = 8'h00;
        SPAA = 8'h00;
        tick(); tick(); tick();
        checks++; if (CPUDO !== 8'h00) begin errors++; $display("FAIL reset_cpudo: got %0h want 00", CPUDO); end
        checks++; if (SPAD !== 8'h00) begin errors++; $display("FAIL reset_spad: got %0h want 00", SPAD); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", BUSY); end
        checks++; if (SWAP !== 1'b0) begin errors++; $display("FAIL reset_swap: got %0b want 0", SWAP); end
        checks++; if (DROP !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b want 0", DROP); end
        checks++; if (BANK !== 1'b0) begin errors++; $display("FAIL reset_bank: got %0b want 0", BANK); end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_first_frame();
        int b, s, dr, sa;
        logic [7:0] f, a, d, e;
        for (int n = 0; n < 256; n++) cpu_write(8'(n), 8'(n) ^ 8'hA5);
        run_copy(1000, 1000, 1000, 1000, b, s, dr, sa, f, a);
        checks++; if (b != 257) begin errors++; $display("FAIL f1_busy_len: got %0d want 257", b); end
        checks++; if (s != 1) begin errors++; $display("FAIL f1_swap_cnt: got %0d want 1", s); end
        checks++; if (sa != 257) begin errors++; $display("FAIL f1_swap_at: got %0d want 257", sa); end
        checks++; if (dr != 0) begin errors++; $display("FAIL f1_drop_cnt: got %0d want 0", dr); end
        checks++; if (BANK !== 1'b1) begin errors++; $display("FAIL f1_bank: got %0b want 1", BANK); end
        for (int n = 0; n < 256; n++) begin
            spr_read(8'(n), d);
            e = 8'(n) ^ 8'hA5;
            checks++; if (d !== e) begin errors++; $display("FAIL f1_spad[%0h]: got %0h want %0h", n, d, e); end
        end
    endtask

    task automatic test_cpu_during_copy();
        int b, s, dr, sa;
        logic [7:0] f, a, d;
        run_copy(1000, 1000, 1000, 8'h80, b, s, dr, sa, f, a);
        checks++; if (s != 1) begin errors++; $display("FAIL f2_swap_cnt: got %0d want 1", s); end
        checks++; if (BANK !== 1'b0) begin errors++; $display("FAIL f2_bank: got %0b want 0", BANK); end
        spr_read(8'h10, d);
        checks++; if (d !== 8'hB5) begin errors++; $display("FAIL f2_spad10: got %0h want b5", d); end
        spr_read(8'hF0, d);
        checks++; if (d !== 8'h44) begin errors++; $display("FAIL f2_spadf0: got %0h want 44", d); end
        spr_read(8'h00, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL f2_spad00: got %0h want a5", d); end
        run_copy(1000, 1000, 1000, 1000, b, s, dr, sa, f, a);
        checks++; if (BANK !== 1'b1) begin errors++; $display("FAIL f3_bank: got %0b want 1", BANK); end
        spr_read(8'h10, d);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL f3_spad10: got %0h want 33", d); end
    endtask

    task automatic test_drop();
        int b, s, dr, sa;
        logic [7:0] f, a, d;
        cpu_write(8'h20, 8'h77);
        run_copy(99, 1000, 1000, 1000, b, s, dr, sa, f, a);
        checks++; if (b != 257) begin errors++; $display("FAIL drop_busy_len: got %0d want 257", b); end
        checks++; if (dr != 1) begin errors++; $display("FAIL drop_cnt: got %0d want 1", dr); end
        checks++; if (s != 0) begin errors++; $display("FAIL drop_swap_cnt: got %0d want 0", s); end
        checks++; if (BANK !== 1'b1) begin errors++; $display("FAIL drop_bank: got %0b want 1", BANK); end
        spr_read(8'h20, d);
        checks++; if (d !== 8'h85) begin errors++; $display("FAIL drop_spad20: got %0h want 85", d); end
        spr_read(8'h10, d);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL drop_spad10: got %0h want 33", d); end
    endtask

    task automatic test_double_rise();
        int b, s, dr, sa;
        logic [7:0] f, a, d;
        run_copy(20, 49, 1000, 1000, b, s, dr, sa, f, a);
        checks++; if (b != 257) begin errors++; $display("FAIL dbl_busy_len: got %0d want 257", b); end
        checks++; if (s != 1) begin errors++; $display("FAIL dbl_swap_cnt: got %0d want 1", s); end
        checks++; if (sa != 257) begin errors++; $display("FAIL dbl_swap_at: got %0d want 257", sa); end
        checks++; if (dr != 0) begin errors++; $display("FAIL dbl_drop_cnt: got %0d want 0", dr); end
        checks++; if (BANK !== 1'b0) begin errors++; $display("FAIL dbl_bank: got %0b want 0", BANK); end
        spr_read(8'h20, d);
        checks++; if (d !== 8'h77) begin errors++; $display("FAIL dbl_spad20: got %0h want 77", d); end
    endtask

    task automatic test_reset_mid_copy();
        int b, s, dr, sa;
        logic [7:0] f, a, d;
        run_copy(1000, 1000, 119, 1000, b, s, dr, sa, f, a);
        checks++; if (b != 120) begin errors++; $display("FAIL rst_busy_len: got %0d want 120", b); end
        checks++; if (s != 0) begin errors++; $display("FAIL rst_swap_cnt: got %0d want 0", s); end
        checks++; if (dr != 0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", dr); end
        checks++; if (BANK !== 1'b0) begin errors++; $display("FAIL rst_bank: got %0b want 0", BANK); end
        spr_read(8'h20, d);
        checks++; if (d !== 8'h77) begin errors++; $display("FAIL rst_spad20: got %0h want 77", d); end
        run_copy(1000, 1000, 1000, 1000, b, s, dr, sa, f, a);
        checks++; if (b != 257) begin errors++; $display("FAIL clean_busy_len: got %0d want 257", b); end
        checks++; if (s != 1) begin errors++; $display("FAIL clean_swap_cnt: got %0d want 1", s); end
        checks++; if (BANK !== 1'b1) begin errors++; $display("FAIL clean_bank: got %0b want 1", BANK); end
        spr_read(8'h00, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL clean_spad00: got %0h want a5", d); end
        spr_read(8'h10, d);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL clean_spad10: got %0h want 33", d); end
        spr_read(8'h20, d);
        checks++; if (d !== 8'h77) begin errors++; $display("FAIL clean_spad20: got %0h want 77", d); end
    endtask

    task automatic test_back_to_back();
        int b, s, dr, sa;
        logic [7:0] f, a;
        cpu_write(8'h55, 8'h99);
        checks++; if (CPUDO !== 8'h99) begin errors++; $display("FAIL wf_cpudo_same: got %0h want 99", CPUDO); end
        tick();
        checks++; if (CPUDO !== 8'h99) begin errors++; $display("FAIL wf_cpudo_next: got %0h want 99", CPUDO); end
        cpu_write(8'hFF, 8'hC3);
        run_copy(1000, 1000, 1000, 1000, b, s, dr, sa, f, a);
        checks++; if (sa != 257) begin errors++; $display("FAIL b2b_swap_at: got %0d want 257", sa); end
        checks++; if (f !== 8'h5A) begin errors++; $display("FAIL flush_spadff_old: got %0h want 5a", f); end
        checks++; if (a !== 8'hC3) begin errors++; $display("FAIL swap_spadff_new: got %0h want c3", a); end
        checks++; if (BANK !== 1'b0) begin errors++; $display("FAIL b2b_bank: got %0b want 0", BANK); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_frame();
        test_cpu_during_copy();
        test_drop();
        test_double_rise();
        test_reset_mid_copy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
